// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// The host inhibits the bus, presents a start bit and then releases ps2_clk.
// The device then generates the clock. The host shifts out 8 data bits LSB
// first, an odd parity bit and the stop bit, and finally samples the device
// ACK. The *_oe outputs are open-drain enables: 1 pulls the pin low.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | tx_ready high, waiting for a byte
// INHIBIT   | ps2_clk held low for the inhibit time
// START     | one cycle with both lines low, then ps2_clk released
// SHIFT     | data/parity/stop driven on each device falling edge
// ACK       | waiting for the 11th falling edge to sample the device ACK
// WAIT_IDLE | waiting for the device to release both lines
module ps2_host_tx #(
    parameter int CLK_FREQ_HZ      = 100_000_000,
    parameter int INHIBIT_US       = 100,
    parameter int START_TIMEOUT_US = 15000,
    parameter int BIT_TIMEOUT_US   = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    // Cycle counts computed in 64 bits so 100 MHz * 15 ms does not overflow.
    localparam longint INHIBIT_CYC = (longint'(INHIBIT_US) * longint'(CLK_FREQ_HZ)) / 1_000_000;
    localparam longint START_CYC   = (longint'(START_TIMEOUT_US) * longint'(CLK_FREQ_HZ)) / 1_000_000;
    localparam longint BIT_CYC     = (longint'(BIT_TIMEOUT_US) * longint'(CLK_FREQ_HZ)) / 1_000_000;
    localparam longint MAX_AB      = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
    localparam longint MAX_CYC     = (MAX_AB > BIT_CYC) ? MAX_AB : BIT_CYC;
    localparam int     CNT_W       = $clog2(MAX_CYC + 1);

    // The timer is a down-counter: loaded with N-1, it expires N cycles later.
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] START_LOAD   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD     = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_SHIFT     = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [3:0]       r_bit_cnt;
    logic [8:0]       r_frame;
    logic             r_tx_ready;
    logic             r_clk_oe;
    logic             r_data_oe;
    logic             r_tx_done;
    logic             r_tx_err;

    logic             r_clk_s1;
    logic             r_clk_s2;
    logic             r_clk_prev;
    logic             r_data_s1;
    logic             r_data_s2;

    logic             w_fall;
    logic             w_expired;
    logic             w_accept;

    // Two-flop synchronizers plus one history flop for falling-edge detection;
    // preset high because an idle PS/2 bus floats high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_i;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data_i;
            r_data_s2  <= r_data_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_expired = (r_timer == '0);
    assign w_accept  = tx_valid & r_tx_ready;

    // Transfer sequencer; every output it drives is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_cnt  <= 4'd0;
            r_frame    <= 9'd0;
            r_tx_ready <= 1'b1;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx_ready <= 1'b1;
                    if (w_accept) begin
                        r_frame    <= {~^tx_data, tx_data};
                        r_tx_ready <= 1'b0;
                        r_tx_err   <= 1'b0;
                        r_clk_oe   <= 1'b1;
                        r_timer    <= INHIBIT_LOAD;
                        r_state    <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (w_expired) begin
                        r_data_oe <= 1'b1;
                        r_state   <= S_START;
                    end else begin
                        r_timer <= r_timer - ONE;
                    end
                end

                S_START: begin
                    r_clk_oe  <= 1'b0;
                    r_bit_cnt <= 4'd0;
                    r_timer   <= START_LOAD;
                    r_state   <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (w_fall) begin
                        r_timer   <= BIT_LOAD;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd9) begin
                            r_data_oe <= 1'b0;
                            r_state   <= S_ACK;
                        end else begin
                            // Frame is consumed LSB first: d0..d7, then parity.
                            r_data_oe <= ~r_frame[0];
                            r_frame   <= {1'b0, r_frame[8:1]};
                        end
                    end else if (w_expired) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_tx_done <= 1'b1;
                        r_tx_err  <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - ONE;
                    end
                end

                S_ACK: begin
                    if (w_fall) begin
                        // Device pulls data low to acknowledge; high means NACK.
                        r_tx_err <= r_data_s2;
                        r_timer  <= BIT_LOAD;
                        r_state  <= S_WAIT_IDLE;
                    end else if (w_expired) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_tx_done <= 1'b1;
                        r_tx_err  <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - ONE;
                    end
                end

                S_WAIT_IDLE: begin
                    if (r_clk_s2 && r_data_s2) begin
                        r_tx_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (w_expired) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_tx_done <= 1'b1;
                        r_tx_err  <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - ONE;
                    end
                end

                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = r_tx_ready;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = (r_state != S_IDLE);
    assign tx_done     = r_tx_done;
    assign tx_err      = r_tx_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model, a PS/2 device model that
// clocks at a 40-cycle period, and a scoreboard of expected frames/results.
module tb_ps2_host_tx;

    localparam int INH_CYC  = 100;
    localparam int START_TO = 1500;
    localparam int BIT_TO   = 200;
    localparam int SYNC_LAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_pin;
    logic       ps2_data_pin;

    assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

    int n_vec = 0;
    int n_miscompare = 0;
    int cyc = 0;
    int n_acc = 0;
    int last_acc_cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int t_fall = 0;
    bit chk_ready_next = 1'b0;

    logic [10:0] q_frame[$];
    logic        q_err[$];

    ps2_host_tx #(
        .CLK_FREQ_HZ      (1_000_000),
        .INHIBIT_US       (100),
        .START_TIMEOUT_US (1500),
        .BIT_TIMEOUT_US   (200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2_clk_pin),
        .ps2_data_i  (ps2_data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame as the device samples it: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        int  ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        par = ((ones % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    // Cycle counter and accept monitor
    always @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            n_acc++;
            last_acc_cyc = cyc;
        end
        cyc++;
    end

    // Result monitor: pops the expected error flag on every tx_done
    always @(negedge clk) begin
        if (chk_ready_next) begin
            check_eq("ready_after_done", 32'(tx_ready), 32'd1);
            check_eq("done_one_cycle", 32'(tx_done), 32'd0);
            chk_ready_next = 1'b0;
        end
        if (tx_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            check_eq("oe_released_at_done", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            check_eq("ready_low_at_done", 32'(tx_ready), 32'd0);
            check_eq("done_expected", 32'(q_err.size() != 0), 32'd1);
            if (q_err.size() != 0) check_eq("tx_err", 32'(tx_err), 32'(q_err.pop_front()));
            chk_ready_next = 1'b1;
        end
    end

    task automatic send(input logic [7:0] d, input bit exp_err, input bit full_frame);
        int w;
        w = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        q_err.push_back(exp_err);
        if (full_frame) q_frame.push_back(exp_frame(d));
        while (!tx_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("accept_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device: waits for the host to release ps2_clk with the start bit set,
    // then generates n_falls clock pulses, sampling data in each high phase.
    task automatic dev_xfer(input int n_falls, input bit nack);
        logic [10:0] bits;
        int w;
        bits = '0;
        w = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < 400) begin
            @(negedge clk);
            w++;
        end
        check_eq("host_release_seen", 32'(w < 400), 32'd1);
        for (int f = 1; f <= n_falls; f++) begin
            repeat (10) @(negedge clk);
            bits[f-1] = ps2_data_pin;
            if (f == 11 && !nack) dev_data_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b1;
            t_fall = cyc;
            repeat (20) @(negedge clk);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
        end
        if (n_falls == 11) begin
            check_eq("frame_expected", 32'(q_frame.size() != 0), 32'd1);
            if (q_frame.size() != 0) check_eq("frame", 32'(bits), 32'(q_frame.pop_front()));
        end
    endtask

    task automatic wait_done(input int n0, input int budget);
        int w;
        w = 0;
        while (done_cnt <= n0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        check_eq("done_seen", 32'(done_cnt > n0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int a0;
        int cnt;
        int w;
        int t0;

        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 32'({tx_ready, busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}), 32'b100000);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 0xF4 with ACK, including inhibit timing
        n0 = done_cnt;
        send(8'hF4, 1'b0, 1'b1);
        check_eq("busy_in_transfer", 32'(busy), 32'd1);
        cnt = 0;
        w   = 0;
        while (ps2_data_oe == 1'b0 && w < 300) begin
            if (ps2_clk_oe) cnt++;
            @(negedge clk);
            w++;
        end
        check_eq("inhibit_cycles", 32'(cnt), 32'(INH_CYC));
        check_eq("start_under_clk_low", 32'(ps2_clk_oe), 32'd1);
        dev_xfer(11, 1'b0);
        wait_done(n0, 300);
        repeat (50) @(negedge clk);
        check_eq("single_done_pulse", 32'(done_cnt - n0), 32'd1);
        check_eq("idle_after_done", 32'({busy, tx_ready}), 32'b01);

        // 0xFF and 0x00: parity bit 1
        for (int k = 0; k < 2; k++) begin
            logic [7:0] d;
            d = (k == 0) ? 8'hFF : 8'h00;
            n0 = done_cnt;
            send(d, 1'b0, 1'b1);
            dev_xfer(11, 1'b0);
            wait_done(n0, 300);
        end

        // NACK from the device
        n0 = done_cnt;
        send(8'hF4, 1'b1, 1'b1);
        dev_xfer(11, 1'b1);
        wait_done(n0, 300);

        // Device never clocks
        n0 = done_cnt;
        send(8'hF4, 1'b1, 1'b0);
        w = 0;
        while (ps2_clk_oe && w < 300) begin
            @(negedge clk);
            w++;
        end
        t0 = cyc;
        wait_done(n0, START_TO + 100);
        check_eq("start_timeout_cycles", 32'(last_done_cyc - t0), 32'(START_TO));

        // Device stalls after the 4th falling edge
        n0 = done_cnt;
        send(8'hF4, 1'b1, 1'b0);
        dev_xfer(4, 1'b0);
        wait_done(n0, BIT_TO + 100);
        check_eq("bit_timeout_cycles", 32'(last_done_cyc - t_fall), 32'(BIT_TO + SYNC_LAT));

        // Asynchronous reset in the middle of SHIFT
        send(8'hF4, 1'b0, 1'b0);
        dev_xfer(2, 1'b0);
        check_eq("shift_d1_driven", 32'({busy, ps2_data_oe}), 32'b11);
        n0 = done_cnt;
        #2 rst = 1'b0;
        #1;
        check_eq("async_reset_release",
                 32'({ps2_clk_oe, ps2_data_oe, tx_ready, busy}), 32'b0010);
        void'(q_err.pop_back());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        check_eq("no_done_after_reset", 32'(done_cnt), 32'(n0));
        n0 = done_cnt;
        send(8'hF4, 1'b0, 1'b1);
        dev_xfer(11, 1'b0);
        wait_done(n0, 300);

        // tx_valid held high across a transfer
        n0 = done_cnt;
        a0 = n_acc;
        @(negedge clk);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        q_err.push_back(1'b0);
        q_frame.push_back(exp_frame(8'hF4));
        w = 0;
        while (n_acc == a0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        tx_data = 8'h00;
        q_err.push_back(1'b0);
        q_frame.push_back(exp_frame(8'h00));
        dev_xfer(11, 1'b0);
        check_eq("single_accept_while_busy", 32'(n_acc - a0), 32'd1);
        wait_done(n0, 300);
        w = 0;
        while (n_acc == a0 + 1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        tx_valid = 1'b0;
        check_eq("second_accept", 32'(n_acc - a0), 32'd2);
        check_eq("accept_after_done", 32'(last_acc_cyc > last_done_cyc), 32'd1);
        n0 = done_cnt;
        dev_xfer(11, 1'b0);
        wait_done(n0, 300);

        repeat (20) @(negedge clk);
        check_eq("scoreboard_empty", 32'(q_err.size() + q_frame.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
